genie_mem_port_mux: RTL and testbench
=====================================

// Module: genie_mem_port_mux
// PURPOSE
//  Parametrised memory-port multiplexer between N layer engines (FC, conv, pool, ...) and the single
//  external read/write memory port. The decoder selects one engine at a time. Read responses are
//  counted, and an engine switch is deferred until the old engine's reads have all returned, so
//  in-flight data is never delivered to the new engine. Sits at the top level, between the engine
//  data loaders and the memory bus.
// PARAMETERS
//  N_ENG      4   number of engine ports
//  SELW       2   engine-select width, >= clog2(N_ENG)
//  AW         26  memory word-address width
//  DW         32  memory data width
//  MAX_OUTST  15  max outstanding read requests (counter width = clog2(MAX_OUTST+1))
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-high
//  sel_in     in   SELW     requested engine index
//  sel_load   in   1        1-cycle strobe: switch to sel_in
//  sel_cur    out  SELW     engine currently owning the port
//  sel_ok     out  1        1 = sel_cur is a valid, connected engine
//  sel_ack    out  1        1-cycle pulse: switch completed
//  busy       out  1        draining outstanding reads before a switch
//  err        out  1        sticky: bad select index, or read response with no read outstanding
//  e_wvalid   in   N_ENG    per-engine write request
//  e_wready   out  N_ENG    per-engine write accept
//  e_waddr    in   N_ENG*AW packed write addresses (engine i at [i*AW +: AW])
//  e_wdata    in   N_ENG*DW packed write data
//  e_rvalid   in   N_ENG    per-engine read request
//  e_rstall   out  N_ENG    1 = read request not forwarded this cycle; engine must hold it
//  e_raddr    in   N_ENG*AW packed read addresses
//  e_rready   out  N_ENG    per-engine read-response strobe
//  e_rdata    out  N_ENG*DW per-engine read data; zero unless that engine's e_rready is 1
//  wvalid     out  1        memory write request
//  wready     in   1        memory write accept
//  waddr      out  AW       memory write address
//  wdata      out  DW       memory write data
//  rvalid     out  1        memory read request; accepted in the cycle it is high
//  raddr      out  AW       memory read address
//  rready     in   1        memory read-response strobe; responses return in order
//  rdata      in   DW       memory read data
// BEHAVIOUR
//  Reset: state IDLE, sel_cur=0, sel_ok=0, cnt=0, err=0, sel_ack=0, busy=0.
//   wvalid=rvalid=0, e_wready=e_rready=0, e_rstall=all 1, e_rdata=0, waddr/raddr/wdata=0.
//  States:
//   IDLE   - no owner; every engine output is blocked.
//   ACTIVE - owner o = sel_cur.
//   DRAIN  - waiting for outstanding reads before switching.
//  IDLE   --sel_load--> DRAIN.
//  ACTIVE --sel_load--> DRAIN, including a reload of the same index.
//  DRAIN  --cnt==0-->   switch to the pending target:
//   valid index (sel_in < N_ENG): sel_cur<=target, sel_ok<=1, state ACTIVE, sel_ack pulses.
//   invalid index (>= N_ENG): sel_ok<=0, err<=1, state IDLE, sel_ack still pulses.
//  Pending target register: loaded from sel_in on every sel_load; a sel_load during DRAIN overwrites it.
//  Latency: sel_load at cycle t with cnt==0 -> busy=1 at t+1, sel_ack=1 at t+2 (new owner live at t+2).
//  busy = (state==DRAIN).
//  Write path, ACTIVE only, combinational pass-through:
//   wvalid=e_wvalid[o], waddr/wdata=owner slice, e_wready[o]=wready; all other e_wready=0.
//  Read request path, ACTIVE only:
//   rvalid = e_rvalid[o] & (cnt < MAX_OUTST); raddr = owner slice.
//   e_rstall[o] = (cnt==MAX_OUTST); all non-owners have e_rstall=1.
//  DRAIN and IDLE: wvalid=rvalid=0, no new requests issued, all e_wready=0, all e_rstall=1.
//  Read response path, all states:
//   rready routed to engine r = last owner (sel_cur is held through DRAIN).
//   e_rready[r]=rready, e_rdata slice r = rdata; all other slices zero.
//  Outstanding counter cnt:
//   +1 on an accepted rvalid; -1 on rready; both in the same cycle -> unchanged.
//   rready with cnt==0: response dropped (no e_rready), err<=1, cnt stays 0.
//   No stall bypass: at cnt==MAX_OUTST a response arriving that cycle does not release the stall
//   until the next cycle.
//  err is cleared only by rst. A mid-operation rst abandons outstanding reads; a late rready then
//   sets err.
// TESTING
//  1 Reset, sel_in=1, sel_load pulse -> sel_ack at +2, sel_cur=1, sel_ok=1.
//    FC write 0x1234 to addr 0x100 -> wvalid/waddr/wdata mirrored, e_wready[1]=wready.
//  2 Owner 1 issues 3 reads; switch to 2 while memory responses are delayed 5 cycles ->
//    busy held until 3rd rready, all 3 routed to e_rready[1], then sel_ack with sel_cur=2;
//    e_rdata[2] stays 0 throughout.
//  3 MAX_OUTST=15, 20 back-to-back reads, no responses -> rvalid for exactly 15 cycles,
//    then e_rstall[o]=1; one rready -> 1 more read issued on the following cycle.
//  4 Simultaneous rvalid accept and rready at cnt=7 -> cnt stays 7.
//    rready at cnt=0 -> dropped, err=1.
//  5 sel_load 3 then sel_load 0 during DRAIN -> final sel_cur=0, single sel_ack.
//    sel_in=5 (N_ENG=4) -> IDLE, sel_ok=0, err=1.
//  6 rst asserted mid-DRAIN with cnt=2 -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/genie_mem_port_mux.sv
// Memory-port multiplexer: one of N_ENG layer engines owns the external read/write port at a time.
// Owner switches wait until every read the old owner issued has returned.
module genie_mem_port_mux #(
  parameter int N_ENG     = 4,
  parameter int SELW      = 2,
  parameter int AW        = 26,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SELW-1:0]     sel_in,
  input  logic                sel_load,
  output logic [SELW-1:0]     sel_cur,
  output logic                sel_ok,
  output logic                sel_ack,
  output logic                busy,
  output logic                err,
  input  logic [N_ENG-1:0]    e_wvalid,
  output logic [N_ENG-1:0]    e_wready,
  input  logic [N_ENG*AW-1:0] e_waddr,
  input  logic [N_ENG*DW-1:0] e_wdata,
  input  logic [N_ENG-1:0]    e_rvalid,
  output logic [N_ENG-1:0]    e_rstall,
  input  logic [N_ENG*AW-1:0] e_raddr,
  output logic [N_ENG-1:0]    e_rready,
  output logic [N_ENG*DW-1:0] e_rdata,
  output logic                wvalid,
  input  logic                wready,
  output logic [AW-1:0]       waddr,
  output logic [DW-1:0]       wdata,
  output logic                rvalid,
  output logic [AW-1:0]       raddr,
  input  logic                rready,
  input  logic [DW-1:0]       rdata
);

  localparam int               CW      = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_OUTST);
  localparam logic [SELW:0]    N_ENG_L = (SELW + 1)'(N_ENG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SELW-1:0] target;
  logic [CW-1:0]   cnt;
  logic            tgt_valid;
  logic            drain_done;
  logic            resp_ok;
  logic            rd_inc;
  logic            rd_dec;

  assign tgt_valid = ({1'b0, target} < N_ENG_L);
  assign busy      = (state == DRAIN);
  // A response with nothing outstanding is orphaned; it is dropped, not delivered.
  assign resp_ok   = rready & (cnt != '0);
  assign rd_inc    = rvalid;
  assign rd_dec    = resp_ok;

  // A new sel_load while draining retargets and keeps draining, so only one ack is produced.
  assign drain_done = (state == DRAIN) && !sel_load && (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_load) state_nxt = DRAIN;
      end
      ACTIVE: begin
        if (sel_load) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = tgt_valid ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_cur <= '0;
      sel_ok  <= 1'b0;
      sel_ack <= 1'b0;
      target  <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_ack <= drain_done;
      if (sel_load) target <= sel_in;
      if (drain_done) begin
        if (tgt_valid) begin
          sel_cur <= target;
          sel_ok  <= 1'b1;
        end else begin
          sel_ok  <= 1'b0;
          err     <= 1'b1;
        end
      end
      if (rready && (cnt == '0)) err <= 1'b1;
      case ({rd_inc, rd_dec})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Request paths open only while ACTIVE; responses always follow sel_cur, which holds through DRAIN.
  always_comb begin
    wvalid   = 1'b0;
    waddr    = '0;
    wdata    = '0;
    rvalid   = 1'b0;
    raddr    = '0;
    e_wready = '0;
    e_rstall = '1;
    e_rready = '0;
    e_rdata  = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (sel_cur == SELW'(i)) begin
        e_rready[i] = resp_ok;
        if (resp_ok) e_rdata[i*DW +: DW] = rdata;
        if (state == ACTIVE) begin
          wvalid      = e_wvalid[i];
          waddr       = e_waddr[i*AW +: AW];
          wdata       = e_wdata[i*DW +: DW];
          e_wready[i] = wready;
          rvalid      = e_rvalid[i] & (cnt < CNT_MAX);
          raddr       = e_raddr[i*AW +: AW];
          e_rstall[i] = (cnt == CNT_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_genie_mem_port_mux.sv
// Directed bench for genie_mem_port_mux: ownership switching, drain, read credit limit and error flag.
module tb_genie_mem_port_mux;

  localparam int N_ENG     = 4;
  localparam int SELW      = 3;
  localparam int AW        = 26;
  localparam int DW        = 32;
  localparam int MAX_OUTST = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic [SELW-1:0]     sel_in;
  logic                sel_load;
  logic [SELW-1:0]     sel_cur;
  logic                sel_ok, sel_ack, busy, err;
  logic [N_ENG-1:0]    e_wvalid, e_wready, e_rvalid, e_rstall, e_rready;
  logic [N_ENG*AW-1:0] e_waddr, e_raddr;
  logic [N_ENG*DW-1:0] e_wdata, e_rdata;
  logic                wvalid, wready, rvalid, rready;
  logic [AW-1:0]       waddr, raddr;
  logic [DW-1:0]       wdata, rdata;

  int n_err = 0;
  int n_chk = 0;
  int n_iss;

  genie_mem_port_mux #(
    .N_ENG(N_ENG), .SELW(SELW), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .sel_load(sel_load), .sel_cur(sel_cur),
    .sel_ok(sel_ok), .sel_ack(sel_ack), .busy(busy), .err(err),
    .e_wvalid(e_wvalid), .e_wready(e_wready), .e_waddr(e_waddr), .e_wdata(e_wdata),
    .e_rvalid(e_rvalid), .e_rstall(e_rstall), .e_raddr(e_raddr), .e_rready(e_rready),
    .e_rdata(e_rdata), .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rvalid(rvalid), .raddr(raddr), .rready(rready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [127:0] slice_at(input int i, input logic [31:0] v);
    logic [127:0] r;
    r = 128'(v) << (i * 32);
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel_cur"}, sel_cur, 0);
    chk({tag, "_sel_ok"}, sel_ok, 0);
    chk({tag, "_sel_ack"}, sel_ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_e_wready"}, e_wready, 0);
    chk({tag, "_e_rstall"}, e_rstall, 4'hF);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_e_rdata"}, e_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every engine requesting: nothing may leak to the memory side.
    rst = 1'b1; sel_in = '0; sel_load = 1'b0;
    e_wvalid = '1; e_rvalid = '1; wready = 1'b1; rready = 1'b0; rdata = '0;
    e_waddr = '0; e_wdata = '0; e_raddr = '0;
    for (int i = 0; i < N_ENG; i++) begin
      e_waddr[i*AW +: AW] = AW'(32'h10 + i);
      e_wdata[i*DW +: DW] = 32'h5500 + i;
      e_raddr[i*AW +: AW] = AW'(32'h20 + i);
    end
    tick(); tick();
    settle();
    chk_reset_outputs("rst");
    rst = 1'b0; e_wvalid = '0; e_rvalid = '0; wready = 1'b0;
    tick();

    // T1: select engine 1, ack two cycles after the load, then a mirrored write.
    sel_in = 3'd1; sel_load = 1'b1; settle();
    chk("t1_busy_pre", busy, 0);
    tick(); sel_load = 1'b0; settle();
    chk("t1_busy", busy, 1);
    chk("t1_ack_early", sel_ack, 0);
    tick(); settle();
    chk("t1_ack", sel_ack, 1);
    chk("t1_sel_cur", sel_cur, 1);
    chk("t1_sel_ok", sel_ok, 1);
    chk("t1_busy_done", busy, 0);
    e_wvalid = 4'b0011;
    e_waddr[0 +: AW] = 26'h3FF; e_wdata[0 +: DW] = 32'hDEAD;
    e_waddr[AW +: AW] = 26'h100; e_wdata[DW +: DW] = 32'h1234;
    wready = 1'b1; settle();
    chk("t1_wvalid", wvalid, 1);
    chk("t1_waddr", waddr, 26'h100);
    chk("t1_wdata", wdata, 32'h1234);
    chk("t1_e_wready", e_wready, 4'b0010);
    wready = 1'b0; settle();
    chk("t1_e_wready_low", e_wready, 0);
    tick(); e_wvalid = '0; settle();
    chk("t1_ack_pulse", sel_ack, 0);
    chk("t1_wvalid_off", wvalid, 0);

    // T2: three reads from engine 1, switch to 2, responses arrive late and go to engine 1.
    for (int k = 0; k < 3; k++) begin
      e_rvalid = 4'b0010; e_raddr[AW +: AW] = AW'(32'h200 + k); settle();
      chk("t2_rvalid", rvalid, 1);
      chk("t2_raddr", raddr, 32'h200 + k);
      chk("t2_rstall", e_rstall, 4'b1101);
      tick();
    end
    e_rvalid = '0; sel_in = 3'd2; sel_load = 1'b1; settle();
    chk("t2_no_req", rvalid, 0);
    tick(); sel_load = 1'b0; e_rvalid = 4'b0110; settle();
    chk("t2_drain_busy", busy, 1);
    chk("t2_drain_rvalid", rvalid, 0);
    chk("t2_drain_rstall", e_rstall, 4'hF);
    tick();
    for (int k = 0; k < 3; k++) begin
      rready = 1'b1; rdata = 32'hA000 + k; settle();
      chk("t2_e_rready", e_rready, 4'b0010);
      chk("t2_e_rdata", e_rdata, slice_at(1, 32'hA000 + k));
      chk("t2_busy_hold", busy, 1);
      tick();
    end
    rready = 1'b0; e_rvalid = '0; settle();
    chk("t2_busy_last", busy, 1);
    chk("t2_ack_wait", sel_ack, 0);
    chk("t2_rdata_idle", e_rdata, 0);
    tick(); settle();
    chk("t2_ack", sel_ack, 1);
    chk("t2_sel_cur", sel_cur, 2);
    chk("t2_busy_clr", busy, 0);

    // T3: 20 back-to-back reads with no responses; only 15 may issue.
    n_iss = 0;
    for (int k = 0; k < 20; k++) begin
      e_rvalid = 4'b0100; e_raddr[2*AW +: AW] = AW'(k); settle();
      if (rvalid) n_iss++;
      chk("t3_rstall", e_rstall[2], (k >= 15));
      tick();
    end
    chk("t3_issued", n_iss, 15);
    rready = 1'b1; rdata = 32'hB0B0; settle();
    chk("t3_no_bypass", rvalid, 0);
    chk("t3_still_stall", e_rstall[2], 1);
    chk("t3_resp", e_rready, 4'b0100);
    tick(); rready = 1'b0; settle();
    chk("t3_one_more", rvalid, 1);
    chk("t3_unstall", e_rstall[2], 0);
    tick(); settle();
    chk("t3_full_again", rvalid, 0);
    e_rvalid = '0;

    // T4: drain 15 -> 7, simultaneous issue + response keeps 7, then exactly 7 more responses.
    for (int k = 0; k < 8; k++) begin
      rready = 1'b1; rdata = 32'hC00 + k; settle();
      chk("t4_drain8", e_rready, 4'b0100);
      tick();
    end
    e_rvalid = 4'b0100; rready = 1'b1; rdata = 32'h7777; settle();
    chk("t4_simul_rvalid", rvalid, 1);
    chk("t4_simul_rready", e_rready, 4'b0100);
    tick(); e_rvalid = '0;
    for (int k = 0; k < 7; k++) begin
      rready = 1'b1; rdata = 32'hD00 + k; settle();
      chk("t4_drain7", e_rready, 4'b0100);
      tick();
    end
    rready = 1'b0; settle();
    chk("t4_err_clean", err, 0);

    // T5: load 3 then 0 during DRAIN; one ack, engine 0 wins.
    e_rvalid = 4'b0100; settle();
    chk("t5_read", rvalid, 1);
    tick(); e_rvalid = '0; sel_in = 3'd3; sel_load = 1'b1; settle();
    tick(); sel_in = 3'd0; settle();
    chk("t5_busy", busy, 1);
    tick(); sel_load = 1'b0; rready = 1'b1; rdata = 32'hC0DE; settle();
    chk("t5_busy2", busy, 1);
    chk("t5_e_rready", e_rready, 4'b0100);
    chk("t5_e_rdata", e_rdata, slice_at(2, 32'hC0DE));
    tick(); rready = 1'b0; settle();
    chk("t5_busy3", busy, 1);
    chk("t5_no_ack", sel_ack, 0);
    tick(); settle();
    chk("t5_ack", sel_ack, 1);
    chk("t5_sel_cur", sel_cur, 0);
    chk("t5_sel_ok", sel_ok, 1);
    tick(); settle();
    chk("t5_single_ack", sel_ack, 0);
    chk("t5_idle_busy", busy, 0);
    // Out-of-range index.
    sel_in = 3'd5; sel_load = 1'b1; settle();
    tick(); sel_load = 1'b0; settle();
    chk("t5b_busy", busy, 1);
    chk("t5b_err_pre", err, 0);
    tick(); settle();
    chk("t5b_ack", sel_ack, 1);
    chk("t5b_sel_ok", sel_ok, 0);
    chk("t5b_err", err, 1);
    chk("t5b_busy_clr", busy, 0);
    e_wvalid = '1; e_rvalid = '1; wready = 1'b1; settle();
    chk("t5b_wvalid", wvalid, 0);
    chk("t5b_rvalid", rvalid, 0);
    chk("t5b_e_wready", e_wready, 0);
    chk("t5b_e_rstall", e_rstall, 4'hF);
    tick(); settle();
    chk("t5b_ack_pulse", sel_ack, 0);
    chk("t5b_err_sticky", err, 1);
    e_wvalid = '0; e_rvalid = '0; wready = 1'b0;

    // T6: reset while draining with two reads outstanding; a late response then flags err.
    sel_in = 3'd1; sel_load = 1'b1;
    tick(); sel_load = 1'b0;
    tick(); settle();
    chk("t6_ack", sel_ack, 1);
    chk("t6_sel_cur", sel_cur, 1);
    for (int k = 0; k < 2; k++) begin
      e_rvalid = 4'b0010; settle();
      chk("t6_read", rvalid, 1);
      tick();
    end
    e_rvalid = '0; sel_in = 3'd3; sel_load = 1'b1;
    tick(); sel_load = 1'b0; settle();
    chk("t6_draining", busy, 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    e_wvalid = '1; e_rvalid = '1; wready = 1'b1; settle();
    chk_reset_outputs("t6");
    e_wvalid = '0; e_rvalid = '0; wready = 1'b0;
    rready = 1'b1; rdata = 32'hFACE; settle();
    chk("t6_late_drop", e_rready, 0);
    chk("t6_late_rdata", e_rdata, 0);
    tick(); rready = 1'b0; settle();
    chk("t6_late_err", err, 1);
    chk("t6_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
